// File: rtl/stream_expander.sv
// stream_expander: scatters a dense, lane-0-packed element stream into the set lanes of a placement mask.
// Define STREAM_EXPANDER_ERR_EN to enable packet-boundary alignment checking on err.
module stream_expander #(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_ELEMENTS*$bits(data_t)-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]               in_keep,
    input  logic                                  in_last,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_ELEMENTS-1:0]               mask,
    input  logic                                  mask_last,
    input  logic                                  mask_valid,
    output logic                                  mask_ready,
    output logic [NUM_ELEMENTS*$bits(data_t)-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]               out_keep,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  err
);

    localparam int unsigned N  = NUM_ELEMENTS;
    localparam int unsigned W  = $bits(data_t);
    localparam int unsigned D  = 2 * N;
    localparam int unsigned CW = $clog2(2 * N + 1);
    localparam int unsigned IW = $clog2(D);

    function automatic logic [CW-1:0] f_popcount(input logic [N-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < int'(N); i++) s = s + CW'(v[i]);
        return s;
    endfunction

    data_t           r_buf [D];
    logic [CW-1:0]   r_cnt;
    logic [N*W-1:0]  r_out_data;
    logic [N-1:0]    r_out_keep;
    logic            r_out_last;
    logic            r_out_valid;

    data_t           w_buf_next [D];
    logic [CW-1:0]   w_mask_cnt;
    logic [CW-1:0]   w_keep_cnt;
    logic [CW-1:0]   w_take;
    logic [CW-1:0]   w_base;
    logic [CW-1:0]   w_cnt_next;
    logic [CW-1:0]   w_pre;
    logic [N*W-1:0]  w_out_lanes;
    logic            w_fire;
    logic            w_accept;

    assign in_ready   = (r_cnt <= CW'(N));
    assign mask_ready = w_fire;
    assign out_data   = r_out_data;
    assign out_keep   = r_out_keep;
    assign out_last   = r_out_last;
    assign out_valid  = r_out_valid;

    // Fire decision, head removal, tail append and lane scatter.
    always_comb begin
        w_mask_cnt = f_popcount(mask);
        w_keep_cnt = f_popcount(in_keep);
        w_fire     = mask_valid && (r_cnt >= w_mask_cnt) && (!r_out_valid || out_ready);
        w_accept   = in_valid && in_ready;
        w_take     = w_fire ? w_mask_cnt : '0;
        w_base     = r_cnt - w_take;
        w_cnt_next = w_base + (w_accept ? w_keep_cnt : '0);

        for (int i = 0; i < int'(D); i++) begin
            if (i + int'(w_take) < int'(D)) w_buf_next[i] = r_buf[IW'(i + int'(w_take))];
            else                            w_buf_next[i] = '0;
        end
        if (w_accept) begin
            for (int l = 0; l < int'(N); l++) begin
                if (l < int'(w_keep_cnt))
                    w_buf_next[IW'(int'(w_base) + l)] = data_t'(in_data[l*W +: W]);
            end
        end

        // Fire reads the pre-accept buffer only; unmasked lanes are driven to zero.
        w_pre       = '0;
        w_out_lanes = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (mask[j]) w_out_lanes[j*W +: W] = W'(r_buf[IW'(w_pre)]);
            w_pre = w_pre + CW'(mask[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_fire) begin
                r_out_data  <= w_out_lanes;
                r_out_keep  <= mask;
                r_out_last  <= mask_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_buf <= w_buf_next;
    end

`ifdef STREAM_EXPANDER_ERR_EN
    // One flag per buffered element marking the last element of an input packet.
    logic [D-1:0] r_flag;
    logic [D-1:0] w_flag_next;
    logic         w_err_hit;
    logic         r_err;

    always_comb begin
        for (int i = 0; i < int'(D); i++) begin
            if (i + int'(w_take) < int'(D)) w_flag_next[i] = r_flag[IW'(i + int'(w_take))];
            else                            w_flag_next[i] = 1'b0;
        end
        // An empty last beat closes the packet on the newest buffered element, if any.
        if (w_accept && in_last) begin
            if (w_keep_cnt != '0)
                w_flag_next[IW'(int'(w_base) + int'(w_keep_cnt) - 1)] = 1'b1;
            else if (w_base != '0)
                w_flag_next[IW'(int'(w_base) - 1)] = 1'b1;
        end

        w_err_hit = 1'b0;
        if (w_fire) begin
            for (int i = 0; i < int'(D); i++) begin
                if (r_flag[i] && (i + 1 < int'(w_take))) w_err_hit = 1'b1;
            end
            if (mask_last && ((w_take == '0) || !r_flag[IW'(int'(w_take) - 1)]))
                w_err_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= '0;
            r_err  <= 1'b0;
        end else begin
            r_flag <= w_flag_next;
            if (w_err_hit) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused;
    assign w_unused = in_last;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_stream_expander.sv
// Directed and scoreboard bench for stream_expander with N=4 lanes of 8-bit elements.
module tb_stream_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mask;
    logic        mask_last;
    logic        mask_valid;
    logic        mask_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    stream_expander #(
        .data_t       (logic [7:0]),
        .NUM_ELEMENTS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mask       (mask),
        .mask_last  (mask_last),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  m;
        logic        ml;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] fr_d [100];
    logic [3:0]  fr_k [100];
    logic [3:0]  fr_m [100];
    logic [7:0]  fr_q [$];
    int          fr_got;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        logic [31:0] b;
        b = '0;
        for (int j = 0; j < 4; j++) if (m[j]) b[j*8 +: 8] = 8'hFF;
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one input beat and return just after the accepting edge.
    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) chk({nm, "_push_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Present one mask, wait for it to fire, then check the produced beat.
    task automatic fire(input logic [3:0] m, input logic ml, input logic [31:0] exp, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        mask = m; mask_last = ml; mask_valid = 1'b1;
        #1;
        while (!mask_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!mask_ready) begin
            chk({nm, "_fire_timeout"}, 32'd0, 32'd1);
            mask_valid = 1'b0;
            return;
        end
        @(negedge clk);
        mask_valid = 1'b0;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_keep"},  32'(out_keep),  32'(m));
        chk({nm, "_last"},  32'(out_last),  32'(ml));
        chk({nm, "_data"},  out_data & lane_mask(m), exp & lane_mask(m));
    endtask

    task automatic fr_producer();
        int n;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_data = fr_d[i]; in_keep = fr_k[i]; in_last = 1'b0; in_valid = 1'b1;
            #1;
            n = 0;
            while (!in_ready && n < 1000) begin
                @(negedge clk); #1; n++;
            end
            if (!in_ready) begin
                chk("fr_push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fr_masker();
        int n;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            mask = fr_m[i]; mask_last = 1'b0; mask_valid = 1'b1;
            #1;
            n = 0;
            while (!mask_ready && n < 1000) begin
                @(negedge clk); #1; n++;
            end
            if (!mask_ready) begin
                chk("fr_mask_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk);
        mask_valid = 1'b0;
    endtask

    task automatic fr_consumer();
        int          cyc;
        logic [31:0] exp;
        cyc = 0;
        while (fr_got < 100 && cyc < 5000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (out_valid && out_ready) begin
                exp = '0;
                for (int j = 0; j < 4; j++) begin
                    if (fr_m[fr_got][j] && fr_q.size() > 0) exp[j*8 +: 8] = fr_q.pop_front();
                end
                chk($sformatf("fr_keep%0d", fr_got), 32'(out_keep), 32'(fr_m[fr_got]));
                chk($sformatf("fr_data%0d", fr_got), out_data & lane_mask(fr_m[fr_got]), exp);
                fr_got++;
            end
            cyc++;
        end
    endtask

    initial begin
        logic [3:0]  mm;
        logic [31:0] dd;
        int          kk;
        int          acc;
        logic        exp_rdy [5];

        rst = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0;
        mask = '0; mask_last = 1'b0; mask_valid = 1'b0; out_ready = 1'b1;

        vecs[0] = '{1'b1, 32'h00C3B2A1, 4'b0111, 4'b1011, 1'b0, 32'hC300B2A1};
        vecs[1] = '{1'b1, 32'h44332211, 4'b1111, 4'b1111, 1'b0, 32'h44332211};
        vecs[2] = '{1'b1, 32'h00006655, 4'b0011, 4'b0101, 1'b0, 32'h00660055};
        vecs[3] = '{1'b1, 32'h0D0C0B0A, 4'b1111, 4'b0001, 1'b0, 32'h0000000A};
        vecs[4] = '{1'b0, 32'h00000000, 4'b0000, 4'b1110, 1'b0, 32'h0D0C0B00};
        vecs[5] = '{1'b1, 32'h000000EE, 4'b0001, 4'b0010, 1'b1, 32'h0000EE00};
        vecs[6] = '{1'b0, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 32'h00000000};
        vecs[7] = '{1'b1, 32'h4F3F2F1F, 4'b1111, 4'b1100, 1'b0, 32'h2F1F0000};
        vecs[8] = '{1'b1, 32'h00006F5F, 4'b0011, 4'b1111, 1'b1, 32'h6F5F4F3F};
        vecs[9] = '{1'b1, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 32'h00000000};

        // Reset state
        do_reset();
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_keep",   32'(out_keep),   32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_out_data",   out_data,        32'd0);
        chk("rst_err",        32'(err),        32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_mask_ready", 32'(mask_ready), 32'd0);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].push) push(vecs[v].d, vecs[v].k, 1'b0, $sformatf("vec%0d", v));
            fire(vecs[v].m, vecs[v].ml, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Carry across beats, then a mask that stalls until one more element arrives
        push(32'hD4C3B2A1, 4'b1111, 1'b0, "carry0");
        push(32'h0000F6E5, 4'b0011, 1'b0, "carry1");
        fire(4'b1111, 1'b0, 32'hD4C3B2A1, "carry_m0");
        fire(4'b0101, 1'b0, 32'h00F600E5, "carry_m1");
        @(negedge clk);
        mask = 4'b1000; mask_last = 1'b0; mask_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mask_ready) acc++;
            @(negedge clk);
        end
        chk("stall_mask_ready", 32'(acc), 32'd0);
        push(32'h00000007, 4'b0001, 1'b0, "stall_g");
        @(negedge clk); #1;
        chk("stall_release", 32'(mask_ready), 32'd1);
        @(negedge clk);
        mask_valid = 1'b0;
        chk("stall_keep", 32'(out_keep), 32'h8);
        chk("stall_data", out_data & 32'hFF000000, 32'h07000000);

        // Output back-pressure: empty-mask beat held while input fills the buffer
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        mask = 4'b0000; mask_last = 1'b0; mask_valid = 1'b1;
        #1;
        chk("bp_empty_fire", 32'(mask_ready), 32'd1);
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", c),   32'(out_valid),  32'd1);
            chk($sformatf("bp_keep%0d", c),    32'(out_keep),   32'd0);
            chk($sformatf("bp_mready%0d", c),  32'(mask_ready), 32'd0);
            chk($sformatf("bp_in_ready%0d", c), 32'(in_ready),  32'(exp_rdy[c]));
            if (acc < 2) begin
                in_valid = 1'b1; in_keep = 4'b1111; in_last = 1'b0;
                in_data  = (acc == 0) ? 32'h13121110 : 32'h17161514;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(mask_ready), 32'd1);
        @(negedge clk);
        mask_valid = 1'b0;
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        fire(4'b1111, 1'b0, 32'h13121110, "bp_drain0");
        fire(4'b1111, 1'b0, 32'h17161514, "bp_drain1");

        // Full-rate random traffic against a queue scoreboard
        do_reset();
        for (int i = 0; i < 100; i++) begin
            kk = $urandom_range(0, 4);
            dd = $urandom;
            fr_d[i] = dd;
            fr_k[i] = 4'((1 << kk) - 1);
            for (int l = 0; l < kk; l++) fr_q.push_back(dd[l*8 +: 8]);
            mm = '0;
            while ($countones(mm) < kk) mm[$urandom_range(0, 3)] = 1'b1;
            fr_m[i] = mm;
        end
        fr_got = 0;
        fork
            fr_producer();
            fr_masker();
            fr_consumer();
        join
        out_ready = 1'b1;
        chk("fr_beats", 32'(fr_got), 32'd100);
        chk("fr_leftover", 32'(fr_q.size()), 32'd0);

`ifdef STREAM_EXPANDER_ERR_EN
        // Packet of three elements against a four-lane last mask
        do_reset();
        push(32'h00332211, 4'b0111, 1'b1, "err_pkt0");
        @(negedge clk);
        mask = 4'b1111; mask_last = 1'b1; mask_valid = 1'b1;
        #1;
        chk("err_wait", 32'(mask_ready), 32'd0);
        chk("err_clear", 32'(err), 32'd0);
        push(32'h77665544, 4'b1111, 1'b1, "err_pkt1");
        @(negedge clk); #1;
        chk("err_fire", 32'(mask_ready), 32'd1);
        chk("err_before", 32'(err), 32'd0);
        @(negedge clk);
        mask_valid = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
`else
        chk("err_tied", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
